// File: rtl/img_lut_ctrl_pkg.sv
// Shared definitions for the image LUT control blocks: bank-controller FSM
// states and the tdata byte-rounding helper used to size table streams.
package img_lut_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_SOF = 2'd3
  } lut_state_e;

  // Round a bit width up to the next whole number of bytes.
  function automatic int unsigned byte_round(input int unsigned width);
    return ((width + 32'd7) / 32'd8) * 32'd8;
  endfunction

endpackage

// File: rtl/gamma_lut_bank_ctrl.sv
// Ping-pong gamma LUT bank controller. A table arriving on the table stream
// is written into the shadow bank; once the table is complete the read bank
// flips on the next start-of-frame handshake, so a frame never sees a mix of
// old and new curve entries.
module gamma_lut_bank_ctrl
  import img_lut_ctrl_pkg::*;
#(
  parameter int unsigned PX_WIDTH        = 32'd10,
  parameter int unsigned TBL_TDATA_WIDTH = byte_round(PX_WIDTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tbl_tvalid_i,
  output logic                       tbl_tready_o,
  input  logic [TBL_TDATA_WIDTH-1:0] tbl_tdata_i,
  input  logic                       tbl_tlast_i,
  input  logic                       video_tvalid_i,
  input  logic                       video_tready_i,
  input  logic                       video_tuser_i,
  output logic                       lut_wr_en_o,
  output logic                       lut_wr_bank_o,
  output logic [PX_WIDTH-1:0]        lut_wr_addr_o,
  output logic [PX_WIDTH-1:0]        lut_wr_data_o,
  output logic                       lut_rd_bank_o,
  output logic                       busy_o,
  output logic                       swap_o,
  output logic                       err_o
);

  localparam logic [PX_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [PX_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [PX_WIDTH-1:0] ADDR_ONE  = {{(PX_WIDTH-1){1'b0}}, 1'b1};

  lut_state_e          state_r;
  lut_state_e          state_nxt_s;
  logic [PX_WIDTH-1:0] addr_r;
  logic [PX_WIDTH-1:0] addr_nxt_s;
  logic                active_bank_r;
  logic                active_bank_nxt_s;
  logic                wr_en_r;
  logic                wr_en_nxt_s;
  logic [PX_WIDTH-1:0] wr_addr_r;
  logic [PX_WIDTH-1:0] wr_addr_nxt_s;
  logic [PX_WIDTH-1:0] wr_data_r;
  logic [PX_WIDTH-1:0] wr_data_nxt_s;
  logic                swap_r;
  logic                swap_nxt_s;
  logic                err_r;
  logic                err_nxt_s;

  logic                tbl_tready_s;
  logic                tbl_hs_s;
  logic                sof_hs_s;
  logic                sof_pending_s;
  logic [PX_WIDTH-1:0] tbl_entry_s;

  // The table stream is only held off while a complete table waits for SOF.
  assign tbl_tready_s  = (state_r != ST_WAIT_SOF);
  assign tbl_hs_s      = tbl_tvalid_i & tbl_tready_s;
  assign sof_hs_s      = video_tvalid_i & video_tready_i & video_tuser_i;
  assign tbl_entry_s   = tbl_tdata_i[PX_WIDTH-1:0];
  // Presenting the SOF beat already selects the new bank, so the SOF pixel is
  // looked up in it even while the beat is stalled by tready.
  assign sof_pending_s = (state_r == ST_WAIT_SOF) & video_tvalid_i & video_tuser_i;

  generate
    if (TBL_TDATA_WIDTH > PX_WIDTH) begin : g_pad
      logic unused_pad_s;
      assign unused_pad_s = ^tbl_tdata_i[TBL_TDATA_WIDTH-1:PX_WIDTH];
    end
  endgenerate

  // Next-state, address counter and registered-output next values.
  always_comb begin
    state_nxt_s       = state_r;
    addr_nxt_s        = addr_r;
    active_bank_nxt_s = active_bank_r;
    wr_en_nxt_s       = 1'b0;
    wr_addr_nxt_s     = wr_addr_r;
    wr_data_nxt_s     = wr_data_r;
    swap_nxt_s        = 1'b0;
    err_nxt_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tbl_hs_s) begin
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = ADDR_ZERO;
          wr_data_nxt_s = tbl_entry_s;
          addr_nxt_s    = ADDR_ONE;
          state_nxt_s   = tbl_tlast_i ? ST_DRAIN : ST_LOAD;
        end else begin
          addr_nxt_s    = ADDR_ZERO;
        end
      end
      ST_LOAD: begin
        if (tbl_hs_s) begin
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = addr_r;
          wr_data_nxt_s = tbl_entry_s;
          if (addr_r == ADDR_LAST) begin
            // Table is full; the counter holds rather than wrapping.
            state_nxt_s = tbl_tlast_i ? ST_WAIT_SOF : ST_DRAIN;
          end else if (tbl_tlast_i) begin
            // Short table: shadow bank is now partial, never swap it in.
            state_nxt_s = ST_IDLE;
            addr_nxt_s  = ADDR_ZERO;
            err_nxt_s   = 1'b1;
          end else begin
            addr_nxt_s  = addr_r + ADDR_ONE;
          end
        end else begin
          addr_nxt_s = addr_r;
        end
      end
      ST_DRAIN: begin
        if (tbl_hs_s && tbl_tlast_i) begin
          state_nxt_s = ST_IDLE;
          addr_nxt_s  = ADDR_ZERO;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_WAIT_SOF: begin
        if (sof_hs_s) begin
          active_bank_nxt_s = ~active_bank_r;
          swap_nxt_s        = 1'b1;
          state_nxt_s       = ST_IDLE;
          addr_nxt_s        = ADDR_ZERO;
        end else begin
          state_nxt_s       = ST_WAIT_SOF;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        addr_nxt_s  = ADDR_ZERO;
      end
    endcase
  end

  // State, counter, active bank and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      addr_r        <= ADDR_ZERO;
      active_bank_r <= 1'b0;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= ADDR_ZERO;
      wr_data_r     <= ADDR_ZERO;
      swap_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      addr_r        <= addr_nxt_s;
      active_bank_r <= active_bank_nxt_s;
      wr_en_r       <= wr_en_nxt_s;
      wr_addr_r     <= wr_addr_nxt_s;
      wr_data_r     <= wr_data_nxt_s;
      swap_r        <= swap_nxt_s;
      err_r         <= err_nxt_s;
    end
  end

  assign tbl_tready_o  = tbl_tready_s;
  assign lut_wr_en_o   = wr_en_r;
  assign lut_wr_bank_o = ~active_bank_r;
  assign lut_wr_addr_o = wr_addr_r;
  assign lut_wr_data_o = wr_data_r;
  assign lut_rd_bank_o = active_bank_r ^ sof_pending_s;
  assign busy_o        = (state_r != ST_IDLE);
  assign swap_o        = swap_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_gamma_lut_bank_ctrl.sv
// Directed bench for gamma_lut_bank_ctrl: table loads of several lengths,
// SOF handling (plain, stalled, coincident with last beat), reset mid-load.
// Expected LUT writes go into a queue when a beat is driven and are popped
// by a monitor when the DUT presents a write.
module tb_gamma_lut_bank_ctrl;

  localparam int PXW   = 10;
  localparam int TDW   = 16;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic           bank;
    logic [PXW-1:0] addr;
    logic [PXW-1:0] data;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           tbl_tvalid_i;
  logic           tbl_tready_o;
  logic [TDW-1:0] tbl_tdata_i;
  logic           tbl_tlast_i;
  logic           video_tvalid_i;
  logic           video_tready_i;
  logic           video_tuser_i;
  logic           lut_wr_en_o;
  logic           lut_wr_bank_o;
  logic [PXW-1:0] lut_wr_addr_o;
  logic [PXW-1:0] lut_wr_data_o;
  logic           lut_rd_bank_o;
  logic           busy_o;
  logic           swap_o;
  logic           err_o;

  wr_t  exp_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   swap_seen = 0;
  int   exp_swaps = 0;
  logic exp_active = 1'b0;

  always #5 clk = ~clk;

  gamma_lut_bank_ctrl #(.PX_WIDTH(PXW), .TBL_TDATA_WIDTH(TDW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .tbl_tvalid_i   (tbl_tvalid_i),
    .tbl_tready_o   (tbl_tready_o),
    .tbl_tdata_i    (tbl_tdata_i),
    .tbl_tlast_i    (tbl_tlast_i),
    .video_tvalid_i (video_tvalid_i),
    .video_tready_i (video_tready_i),
    .video_tuser_i  (video_tuser_i),
    .lut_wr_en_o    (lut_wr_en_o),
    .lut_wr_bank_o  (lut_wr_bank_o),
    .lut_wr_addr_o  (lut_wr_addr_o),
    .lut_wr_data_o  (lut_wr_data_o),
    .lut_rd_bank_o  (lut_rd_bank_o),
    .busy_o         (busy_o),
    .swap_o         (swap_o),
    .err_o          (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write monitor: samples 3 time units after each rising edge.
  always begin
    @(posedge clk);
    #3;
    chk("wr_bank_is_compl", {31'd0, lut_wr_bank_o}, {31'd0, ~exp_active});
    chk("wr_en", {31'd0, lut_wr_en_o}, {31'd0, (exp_q.size() != 0)});
    if (lut_wr_en_o === 1'b1 && exp_q.size() != 0) begin
      wr_t e;
      e = exp_q.pop_front();
      chk("wr_bank", {31'd0, lut_wr_bank_o}, {31'd0, e.bank});
      chk("wr_addr", {22'd0, lut_wr_addr_o}, {22'd0, e.addr});
      chk("wr_data", {22'd0, lut_wr_data_o}, {22'd0, e.data});
    end
    if (swap_o === 1'b1) swap_seen++;
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_tready",  {31'd0, tbl_tready_o},  32'd1);
    chk("rst_wr_en",   {31'd0, lut_wr_en_o},   32'd0);
    chk("rst_wr_addr", {22'd0, lut_wr_addr_o}, 32'd0);
    chk("rst_wr_data", {22'd0, lut_wr_data_o}, 32'd0);
    chk("rst_rd_bank", {31'd0, lut_rd_bank_o}, 32'd0);
    chk("rst_wr_bank", {31'd0, lut_wr_bank_o}, 32'd1);
    chk("rst_busy",    {31'd0, busy_o},        32'd0);
    chk("rst_swap",    {31'd0, swap_o},        32'd0);
    chk("rst_err",     {31'd0, err_o},         32'd0);
  endtask

  // One table beat; starts and ends at posedge+1.
  task automatic beat(input logic [TDW-1:0] d, input logic last,
                      input logic exp_wr, input logic [PXW-1:0] a);
    wr_t e;
    tbl_tvalid_i = 1'b1;
    tbl_tdata_i  = d;
    tbl_tlast_i  = last;
    @(negedge clk);
    chk("tbl_tready", {31'd0, tbl_tready_o}, 32'd1);
    if (exp_wr) begin
      e = {~exp_active, a, d[PXW-1:0]};
      exp_q.push_back(e);
    end
    sync();
    tbl_tvalid_i = 1'b0;
    tbl_tlast_i  = 1'b0;
  endtask

  // Send n beats, tlast on beat last_at; beats at index >= DEPTH are not written.
  task automatic send_table(input int n, input int last_at, input logic [PXW-1:0] pat,
                            input logic sof_on_last);
    logic [PXW-1:0] ii;
    for (int i = 0; i < n; i++) begin
      ii = PXW'(i);
      if (sof_on_last && i == n - 1) begin
        video_tvalid_i = 1'b1;
        video_tuser_i  = 1'b1;
        video_tready_i = 1'b1;
      end
      beat({6'h2B, ii ^ pat}, (i == last_at), (i < DEPTH), ii);
      video_tvalid_i = 1'b0;
      video_tuser_i  = 1'b0;
      video_tready_i = 1'b0;
    end
  endtask

  task automatic check_rejected();
    @(negedge clk);
    chk("err_pulse", {31'd0, err_o}, 32'd1);
    chk("idle_after_err", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk("err_one_cycle", {31'd0, err_o}, 32'd0);
    sync();
  endtask

  task automatic check_waiting();
    @(negedge clk);
    chk("wait_busy",   {31'd0, busy_o},       32'd1);
    chk("wait_tready", {31'd0, tbl_tready_o}, 32'd0);
    chk("wait_no_err", {31'd0, err_o},        32'd0);
    sync();
  endtask

  // SOF beat held stalled for 'stall' cycles, then accepted.
  task automatic sof(input int stall, input logic expect_swap);
    video_tvalid_i = 1'b1;
    video_tuser_i  = 1'b1;
    video_tready_i = 1'b0;
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      chk("stall_rd_bank", {31'd0, lut_rd_bank_o}, {31'd0, exp_active ^ expect_swap});
      chk("stall_swap",    {31'd0, swap_o},        32'd0);
      chk("stall_tready",  {31'd0, tbl_tready_o},  {31'd0, ~expect_swap});
      sync();
    end
    video_tready_i = 1'b1;
    @(negedge clk);
    chk("sof_rd_bank", {31'd0, lut_rd_bank_o}, {31'd0, exp_active ^ expect_swap});
    sync();
    video_tvalid_i = 1'b0;
    video_tuser_i  = 1'b0;
    video_tready_i = 1'b0;
    if (expect_swap) begin
      exp_active = ~exp_active;
      exp_swaps++;
    end
    @(negedge clk);
    chk("swap_pulse", {31'd0, swap_o},        {31'd0, expect_swap});
    chk("rd_bank",    {31'd0, lut_rd_bank_o}, {31'd0, exp_active});
    chk("post_sof_busy", {31'd0, busy_o},     32'd0);
    @(negedge clk);
    chk("swap_one_cycle", {31'd0, swap_o}, 32'd0);
    chk("swap_count", swap_seen, exp_swaps);
    sync();
  endtask

  initial begin
    rst_i          = 1'b1;
    tbl_tvalid_i   = 1'b0;
    tbl_tdata_i    = '0;
    tbl_tlast_i    = 1'b0;
    video_tvalid_i = 1'b0;
    video_tready_i = 1'b0;
    video_tuser_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_reset_values();
    sync();

    // Short table: tlast on beat 500 is rejected, SOF afterwards ignored.
    send_table(501, 500, 10'h000, 1'b0);
    check_rejected();
    sof(0, 1'b0);

    // Long table: beats past the last address are drained, then rejected.
    send_table(1030, 1029, 10'h000, 1'b0);
    check_rejected();
    sof(0, 1'b0);

    // Full table, data = address, then a plain SOF: bank 0 -> 1.
    send_table(DEPTH, DEPTH - 1, 10'h000, 1'b0);
    check_waiting();
    sof(0, 1'b1);

    // Second load with SOF on the last beat (ignored), then stalled SOF: 1 -> 0.
    send_table(DEPTH, DEPTH - 1, 10'h3FF, 1'b1);
    check_waiting();
    chk("no_swap_on_last_beat", swap_seen, exp_swaps);
    sof(5, 1'b1);

    // Third load: 0 -> 1, so reset below has a visible bank effect.
    send_table(DEPTH, DEPTH - 1, 10'h155, 1'b0);
    check_waiting();
    sof(0, 1'b1);

    // Reset asserted at beat 300 of a load.
    send_table(300, -1, 10'h0F0, 1'b0);
    tbl_tvalid_i = 1'b1;
    tbl_tdata_i  = 16'h012C;
    rst_i        = 1'b1;
    sync();
    rst_i        = 1'b0;
    tbl_tvalid_i = 1'b0;
    exp_active   = 1'b0;
    @(negedge clk);
    check_reset_values();
    sync();

    // Fresh full load after reset lands in bank 1.
    send_table(DEPTH, DEPTH - 1, 10'h0AA, 1'b0);
    check_waiting();
    sof(0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
